// File: rtl/gerador_varredura_vga.sv
// Raster scan generator for the VGA path: column/line counters, registered
// active-low hsync/vsync and an end-of-frame pulse, advancing on pixel_en.
module gerador_varredura_vga #(
  parameter int H_VISIVEL = 640,
  parameter int H_FRENTE  = 16,
  parameter int H_SINC    = 96,
  parameter int H_TRAS    = 48,
  parameter int V_VISIVEL = 480,
  parameter int V_FRENTE  = 10,
  parameter int V_SINC    = 2,
  parameter int V_TRAS    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pixel_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       fim_quadro
);

  localparam int H_TOTAL = H_VISIVEL + H_FRENTE + H_SINC + H_TRAS;
  localparam int V_TOTAL = V_VISIVEL + V_FRENTE + V_SINC + V_TRAS;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_limite_invalido
      $error("gerador_varredura_vga: H_TOTAL and V_TOTAL must both be <= 1024");
    end
  endgenerate

  localparam logic [9:0] H_ULTIMO     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_INI_FRENTE = 10'(H_VISIVEL);
  localparam logic [9:0] H_INI_SINC   = 10'(H_VISIVEL + H_FRENTE);
  localparam logic [9:0] H_INI_TRAS   = 10'(H_VISIVEL + H_FRENTE + H_SINC);
  localparam logic [9:0] V_ULTIMO     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_INI_FRENTE = 10'(V_VISIVEL);
  localparam logic [9:0] V_INI_SINC   = 10'(V_VISIVEL + V_FRENTE);
  localparam logic [9:0] V_INI_TRAS   = 10'(V_VISIVEL + V_FRENTE + V_SINC);

  typedef enum logic [1:0] {
    VISIVEL = 2'd0,
    FRENTE  = 2'd1,
    SINC    = 2'd2,
    TRAS    = 2'd3
  } fase_t;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  fase_t      h_fase_q, h_fase_d;
  fase_t      v_fase_q, v_fase_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       fim_q, fim_d;
  logic       h_wrap;
  logic       v_wrap;

  // Sync and frame-end are derived from next-state values so they land on
  // the same edge as the counters that define them.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    h_fase_d = h_fase_q;
    v_fase_d = v_fase_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    fim_d    = fim_q;
    h_wrap   = (x_q == H_ULTIMO);
    v_wrap   = (y_q == V_ULTIMO);

    if (pixel_en) begin
      x_d = h_wrap ? 10'd0 : x_q + 10'd1;
      if (h_wrap) begin
        y_d = v_wrap ? 10'd0 : y_q + 10'd1;
      end

      case (h_fase_q)
        VISIVEL: if (x_d == H_INI_FRENTE) h_fase_d = FRENTE;
        FRENTE:  if (x_d == H_INI_SINC)   h_fase_d = SINC;
        SINC:    if (x_d == H_INI_TRAS)   h_fase_d = TRAS;
        TRAS:    if (h_wrap)              h_fase_d = VISIVEL;
        default:                          h_fase_d = VISIVEL;
      endcase

      if (h_wrap) begin
        case (v_fase_q)
          VISIVEL: if (y_d == V_INI_FRENTE) v_fase_d = FRENTE;
          FRENTE:  if (y_d == V_INI_SINC)   v_fase_d = SINC;
          SINC:    if (y_d == V_INI_TRAS)   v_fase_d = TRAS;
          TRAS:    if (v_wrap)              v_fase_d = VISIVEL;
          default:                          v_fase_d = VISIVEL;
        endcase
      end

      hsync_d = (h_fase_d != SINC);
      vsync_d = (v_fase_d != SINC);
      fim_d   = (x_d == H_ULTIMO) && (y_d == V_ULTIMO);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      h_fase_q <= VISIVEL;
      v_fase_q <= VISIVEL;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fim_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      h_fase_q <= h_fase_d;
      v_fase_q <= v_fase_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fim_q    <= fim_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign fim_quadro = fim_q;

endmodule

// File: tb/tb_gerador_varredura_vga.sv
// Bench for gerador_varredura_vga: a default-timing instance and a shrunken
// instance, both checked against a frame-position reference model.
module tb_gerador_varredura_vga;

  localparam int DH_V = 640, DH_F = 16, DH_S = 96, DH_T = 48;
  localparam int DV_V = 480, DV_F = 10, DV_S = 2,  DV_T = 33;
  localparam int DHT  = DH_V + DH_F + DH_S + DH_T;
  localparam int DVT  = DV_V + DV_F + DV_S + DV_T;
  localparam int DFS  = DHT * DVT;

  localparam int SH_V = 20, SH_F = 4, SH_S = 6, SH_T = 5;
  localparam int SV_V = 12, SV_F = 3, SV_S = 2, SV_T = 4;
  localparam int SHT  = SH_V + SH_F + SH_S + SH_T;
  localparam int SVT  = SV_V + SV_F + SV_S + SV_T;
  localparam int SFS  = SHT * SVT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pixel_en = 1'b0;
  logic [9:0] dx, dy, sx, sy;
  logic       dhs, dvs, dfim, shs, svs, sfim;

  int checks = 0;
  int failures = 0;
  int pos_d = 0;
  int pos_s = 0;

  always #5 clk = ~clk;

  gerador_varredura_vga dut_def (
    .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .x(dx), .y(dy), .hsync(dhs), .vsync(dvs), .fim_quadro(dfim)
  );

  gerador_varredura_vga #(
    .H_VISIVEL(SH_V), .H_FRENTE(SH_F), .H_SINC(SH_S), .H_TRAS(SH_T),
    .V_VISIVEL(SV_V), .V_FRENTE(SV_F), .V_SINC(SV_S), .V_TRAS(SV_T)
  ) dut_pq (
    .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .x(sx), .y(sy), .hsync(shs), .vsync(svs), .fim_quadro(sfim)
  );

  // Reference model: each instance is just a linear position inside its frame.
  function automatic logic sync_ref(int c, int vis, int fr, int sn);
    return !((c >= vis + fr) && (c < vis + fr + sn));
  endfunction

  function automatic logic [22:0] esperado_def(int p);
    int c = p % DHT;
    int l = p / DHT;
    return {10'(c), 10'(l), sync_ref(c, DH_V, DH_F, DH_S),
            sync_ref(l, DV_V, DV_F, DV_S), (p == DFS - 1)};
  endfunction

  function automatic logic [22:0] esperado_pq(int p);
    int c = p % SHT;
    int l = p / SHT;
    return {10'(c), 10'(l), sync_ref(c, SH_V, SH_F, SH_S),
            sync_ref(l, SV_V, SV_F, SV_S), (p == SFS - 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      pos_d = 0;
      pos_s = 0;
    end else if (pixel_en) begin
      pos_d = (pos_d + 1) % DFS;
      pos_s = (pos_s + 1) % SFS;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    repeat (3) tick();
    checks += 6;
    if (dx !== 10'd0) begin failures++; $display("[TB] FAIL reset_x: got %0d, expected 0", dx); end
    if (dy !== 10'd0) begin failures++; $display("[TB] FAIL reset_y: got %0d, expected 0", dy); end
    if (dhs !== 1'b1) begin failures++; $display("[TB] FAIL reset_hsync: got %b, expected 1", dhs); end
    if (dvs !== 1'b1) begin failures++; $display("[TB] FAIL reset_vsync: got %b, expected 1", dvs); end
    if (dfim !== 1'b0) begin failures++; $display("[TB] FAIL reset_fim: got %b, expected 0", dfim); end
    if ({sx, sy, shs, svs, sfim} !== esperado_pq(0)) begin
      failures++;
      $display("[TB] FAIL reset_small: got %h, expected %h", {sx, sy, shs, svs, sfim}, esperado_pq(0));
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (dx !== 10'd1 || sx !== 10'd1) begin
      failures++;
      $display("[TB] FAIL first_edge_x: got %0d/%0d, expected 1/1", dx, sx);
    end
  endtask

  task automatic test_horizontal();
    logic       prev_hs = dhs;
    logic       prev_vis = (dx < 10'd640);
    logic [9:0] prev_x = dx, prev_y = dy;
    int falls = 0, rises = 0, wraps = 0, vis_fall_at = -1000;
    pixel_en = 1'b1;
    for (int c = 0; c < 1700; c++) begin
      tick();
      checks++;
      if ({dx, dy, dhs, dvs, dfim} !== esperado_def(pos_d)) begin
        failures++;
        $display("[TB] FAIL horiz_state: got %h, expected %h", {dx, dy, dhs, dvs, dfim}, esperado_def(pos_d));
      end
      if (prev_vis && !(dx < 10'd640)) vis_fall_at = c;
      if (prev_hs && !dhs) begin
        falls++;
        checks += 2;
        if (dx !== 10'd656) begin failures++; $display("[TB] FAIL hsync_fall_x: got %0d, expected 656", dx); end
        if (c - vis_fall_at != 16) begin
          failures++;
          $display("[TB] FAIL comparator_to_hsync: got %0d pixels, expected 16", c - vis_fall_at);
        end
      end
      if (!prev_hs && dhs) begin
        rises++;
        checks++;
        if (dx !== 10'd752) begin failures++; $display("[TB] FAIL hsync_rise_x: got %0d, expected 752", dx); end
      end
      if (prev_x == 10'd799) begin
        wraps++;
        checks++;
        if (dx !== 10'd0 || dy !== prev_y + 10'd1) begin
          failures++;
          $display("[TB] FAIL line_wrap: got (%0d,%0d), expected (0,%0d)", dx, dy, prev_y + 10'd1);
        end
      end
      prev_hs  = dhs;
      prev_vis = (dx < 10'd640);
      prev_x   = dx;
      prev_y   = dy;
    end
    checks++;
    if (falls != 2 || rises != 2 || wraps != 2) begin
      failures++;
      $display("[TB] FAIL horiz_events: got %0d/%0d/%0d, expected 2/2/2", falls, rises, wraps);
    end
  endtask

  task automatic test_reset_mid_frame();
    int alvo = 6 * SHT + 10;
    int budget = SFS + 2;
    pixel_en = 1'b1;
    while (pos_s != alvo && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if ({sx, sy} !== {10'd10, 10'd6}) begin
      failures++;
      $display("[TB] FAIL mid_frame_reach: got (%0d,%0d), expected (10,6)", sx, sy);
    end
    #2;
    reset_n = 1'b0;
    pos_d = 0;
    pos_s = 0;
    #1;
    checks += 2;
    if ({sx, sy, shs, svs, sfim} !== esperado_pq(0)) begin
      failures++;
      $display("[TB] FAIL async_reset_small: got %h, expected %h", {sx, sy, shs, svs, sfim}, esperado_pq(0));
    end
    if ({dx, dy, dhs, dvs, dfim} !== esperado_def(0)) begin
      failures++;
      $display("[TB] FAIL async_reset_def: got %h, expected %h", {dx, dy, dhs, dvs, dfim}, esperado_def(0));
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (sx !== 10'd1 || sy !== 10'd0 || dx !== 10'd1) begin
      failures++;
      $display("[TB] FAIL after_release: got (%0d,%0d) def x %0d, expected (1,0) def x 1", sx, sy, dx);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0, fim_count = 0;
    pixel_en = 1'b1;
    for (int c = 0; c < SFS; c++) begin
      tick();
      checks++;
      if ({sx, sy, shs, svs, sfim} !== esperado_pq(pos_s)) begin
        failures++;
        $display("[TB] FAIL frame_state: got %h, expected %h", {sx, sy, shs, svs, sfim}, esperado_pq(pos_s));
      end
      if (!svs) vs_low++;
      if (sfim) begin
        fim_count++;
        checks++;
        if (sx !== 10'(SHT - 1) || sy !== 10'(SVT - 1)) begin
          failures++;
          $display("[TB] FAIL fim_position: got (%0d,%0d), expected (%0d,%0d)", sx, sy, SHT - 1, SVT - 1);
        end
      end
    end
    checks += 2;
    if (vs_low != SV_S * SHT) begin
      failures++;
      $display("[TB] FAIL vsync_width: got %0d, expected %0d", vs_low, SV_S * SHT);
    end
    if (fim_count != 1) begin
      failures++;
      $display("[TB] FAIL fim_count: got %0d, expected 1", fim_count);
    end
  endtask

  task automatic test_enable_gating();
    logic prev_fim = sfim, prev_hs = shs;
    int   rise1 = -1, rise2 = -1, hs_start = -1, hs_width = -1;
    for (int c = 0; c < 4 * SFS + 2; c++) begin
      pixel_en = (c % 2 == 0);
      tick();
      checks++;
      if ({sx, sy, shs, svs, sfim} !== esperado_pq(pos_s)) begin
        failures++;
        $display("[TB] FAIL gating_state: got %h, expected %h", {sx, sy, shs, svs, sfim}, esperado_pq(pos_s));
      end
      if (!prev_fim && sfim) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      if (prev_hs && !shs) hs_start = c;
      if (!prev_hs && shs && hs_start >= 0 && hs_width < 0) hs_width = c - hs_start;
      prev_fim = sfim;
      prev_hs  = shs;
    end
    pixel_en = 1'b0;
    checks += 2;
    if (rise1 < 0 || rise2 < 0 || rise2 - rise1 != 2 * SFS) begin
      failures++;
      $display("[TB] FAIL gated_frame_clocks: got %0d, expected %0d", rise2 - rise1, 2 * SFS);
    end
    if (hs_width != 2 * SH_S) begin
      failures++;
      $display("[TB] FAIL gated_hsync_width: got %0d, expected %0d", hs_width, 2 * SH_S);
    end
  endtask

  task automatic test_stall_at_wrap();
    int budget = SFS + 2;
    pixel_en = 1'b1;
    while (pos_s != SFS - 1 && budget > 0) begin
      tick();
      budget--;
    end
    pixel_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({sx, sy, shs, svs, sfim} !== {10'(SHT - 1), 10'(SVT - 1), 1'b1, 1'b1, 1'b1}) begin
        failures++;
        $display("[TB] FAIL stall_frozen: got %h, expected %h", {sx, sy, shs, svs, sfim},
                 {10'(SHT - 1), 10'(SVT - 1), 1'b1, 1'b1, 1'b1});
      end
    end
    pixel_en = 1'b1;
    tick();
    pixel_en = 1'b0;
    checks++;
    if (sx !== 10'd0 || sy !== 10'd0 || sfim !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_release: got (%0d,%0d,%b), expected (0,0,0)", sx, sy, sfim);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      pixel_en = 1'($urandom_range(0, 1));
      tick();
      checks += 2;
      if ({sx, sy, shs, svs, sfim} !== esperado_pq(pos_s)) begin
        failures++;
        $display("[TB] FAIL random_small: got %h, expected %h", {sx, sy, shs, svs, sfim}, esperado_pq(pos_s));
      end
      if ({dx, dy, dhs, dvs, dfim} !== esperado_def(pos_d)) begin
        failures++;
        $display("[TB] FAIL random_def: got %h, expected %h", {dx, dy, dhs, dvs, dfim}, esperado_def(pos_d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_reset_mid_frame();
    test_frame();
    test_enable_gating();
    test_stall_at_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
